// File: rtl/crypto_pkg.sv
// Shared definitions for the mini crypto processor: default widths,
// opcode values, ALU operation encodings and the sequencer state type.
package crypto_pkg;

  localparam int AW_DEF = 4;
  localparam int IW_DEF = 8;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDK  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_ROTL = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_JZ   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  localparam logic [1:0] ALU_XOR  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_ROTL = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } cu_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: maps the 4-bit opcode onto the set of
// datapath strobes and control-flow flags used by control_unit in EXEC.
// Instructions that do not use the ALU report the pass-through encoding.
module instr_decoder
  import crypto_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       key_load,
  output logic       reg_we,
  output logic [1:0] alu_op,
  output logic       is_jmp,
  output logic       is_jz,
  output logic       is_halt,
  output logic       illegal
);

  // Opcode to strobe-set lookup; everything above HALT is illegal.
  always_comb begin
    key_load = 1'b0;
    reg_we   = 1'b0;
    alu_op   = ALU_PASS;
    is_jmp   = 1'b0;
    is_jz    = 1'b0;
    is_halt  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_LDK:  key_load = 1'b1;
      OP_XOR:  begin alu_op = ALU_XOR;  reg_we = 1'b1; end
      OP_ADD:  begin alu_op = ALU_ADD;  reg_we = 1'b1; end
      OP_ROTL: begin alu_op = ALU_ROTL; reg_we = 1'b1; end
      OP_JMP:  is_jmp  = 1'b1;
      OP_JZ:   is_jz   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fixed FETCH/DECODE/EXEC loop driving the program
// counter (pc_enable / jump / jump_addr) and the datapath strobes.
// Build option: CU_ILLEGAL_TRAP_EN -- when defined an illegal opcode halts
// the sequencer from DECODE; otherwise it executes as a NOP. fault_pc
// records the address of the last illegal opcode in both builds.
module control_unit
  import crypto_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] pc,
  input  logic [IW-1:0] instr,
  input  logic          zero,
  output logic          pc_enable,
  output logic          jump,
  output logic [AW-1:0] jump_addr,
  output logic [1:0]    alu_op,
  output logic          key_load,
  output logic          reg_we,
  output logic [3:0]    imm,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] fault_pc
);

  cu_state_t     state_reg, state_next;
  logic [IW-1:0] ir_reg;
  logic [AW-1:0] fault_pc_reg;

  logic       dec_key_load;
  logic       dec_reg_we;
  logic [1:0] dec_alu_op;
  logic       dec_is_jmp;
  logic       dec_is_jz;
  logic       dec_is_halt;
  logic       dec_illegal;
  logic       take_jump;

  instr_decoder u_decoder (
    .opcode   (ir_reg[IW-1:IW-4]),
    .key_load (dec_key_load),
    .reg_we   (dec_reg_we),
    .alu_op   (dec_alu_op),
    .is_jmp   (dec_is_jmp),
    .is_jz    (dec_is_jz),
    .is_halt  (dec_is_halt),
    .illegal  (dec_illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Instruction register, loaded from the ROM at the edge closing FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     ir_reg <= '0;
    else if (state_reg == ST_FETCH) ir_reg <= instr;
  end

  // Remember where the most recent illegal opcode was found.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      fault_pc_reg <= '0;
    else if (state_reg == ST_DECODE && dec_illegal)  fault_pc_reg <= pc;
  end

  // JZ is the only strobe that depends on a live input (zero) in EXEC.
  assign take_jump = dec_is_jmp | (dec_is_jz & zero);

  // Next-state logic and EXEC-only strobes.
  always_comb begin
    state_next = state_reg;
    pc_enable  = 1'b0;
    jump       = 1'b0;
    key_load   = 1'b0;
    reg_we     = 1'b0;
    alu_op     = ALU_XOR;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
`ifdef CU_ILLEGAL_TRAP_EN
        state_next = dec_illegal ? ST_HALT : ST_EXEC;
`else
        state_next = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        key_load = dec_key_load;
        reg_we   = dec_reg_we;
        alu_op   = dec_alu_op;
        if (dec_is_halt) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_FETCH;
          jump       = take_jump;
          pc_enable  = ~take_jump;
        end
      end
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign jump_addr = jump ? AW'(ir_reg[3:0]) : '0;
  assign imm       = ir_reg[3:0];
  assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_DECODE) ||
                     (state_reg == ST_EXEC);
  assign halted    = (state_reg == ST_HALT);
  assign fault_pc  = fault_pc_reg;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a behavioural program counter and ROM
// surround the DUT; expected EXEC transactions are queued per scenario and
// a negedge monitor pops and compares each time the DUT issues strobes.
`timescale 1ns/1ps
module tb_control_unit;

  typedef struct packed {
    logic [3:0] pc;
    logic       pe;
    logic       jmp;
    logic [3:0] ja;
    logic       kl;
    logic       we;
    logic [1:0] op;
    logic [3:0] imm;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       zero;
  logic       pc_enable, jump, key_load, reg_we, busy, halted;
  logic [3:0] jump_addr, imm, fault_pc;
  logic [1:0] alu_op;

  logic [7:0]  rom [16];
  logic [15:0] zero_tab = '0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   have_last = 0;
  txn_t sb[$];

  control_unit dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
    .zero(zero), .pc_enable(pc_enable), .jump(jump), .jump_addr(jump_addr),
    .alu_op(alu_op), .key_load(key_load), .reg_we(reg_we), .imm(imm),
    .busy(busy), .halted(halted), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign instr = rom[pc];
  assign zero  = zero_tab[pc];

  // Reference program counter.
  always @(posedge clk or negedge reset) begin
    if (!reset)         pc <= 4'd0;
    else if (jump)      pc <= jump_addr;
    else if (pc_enable) pc <= pc + 4'd1;
  end

  function automatic txn_t t(input logic [3:0] p, input logic pe, input logic jm,
                             input logic [3:0] ja, input logic kl, input logic we,
                             input logic [1:0] op, input logic [3:0] im);
    return {p, pe, jm, ja, kl, we, op, im};
  endfunction

  function automatic string fmt(input txn_t x);
    return $sformatf("pc=%0d pe=%b jmp=%b ja=%0d kl=%b we=%b op=%b imm=%0d",
                     x.pc, x.pe, x.jmp, x.ja, x.kl, x.we, x.op, x.imm);
  endfunction

  // Monitor: every strobe cycle is one transaction; also checks 3-cycle spacing.
  always @(negedge clk) begin : monitor
    txn_t got;
    txn_t req;
    if (reset && (pc_enable || jump || key_load || reg_we)) begin
      got = {pc, pc_enable, jump, jump_addr, key_load, reg_we, alu_op, imm};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_txn got %s required none", fmt(got));
      end else begin
        req = sb.pop_front();
        if (got !== req) begin
          failures++;
          $display("FAIL txn got %s required %s", fmt(got), fmt(req));
        end else begin
          $display("txn ok %s", fmt(got));
        end
      end
      if (have_last) begin
        checks++;
        if (cyc - last_cyc != 3) begin
          failures++;
          $display("FAIL strobe_period got=%0d required=3", cyc - last_cyc);
        end
      end
      last_cyc  = cyc;
      have_last = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end else begin
      $display("check ok %s = %0h", name, got);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {12'd0, pc_enable, jump, jump_addr, alu_op, key_load, reg_we, imm,
            busy, halted, fault_pc};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    zero_tab = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    sb.delete();
    have_last = 1'b0;
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle with start low.
    clear_rom();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", all_outs(), 32'd0);
    end

    // Four NOPs then HALT; start pulsed again while halted.
    clear_rom();
    rom[4] = 8'h70;
    do_reset();
    for (int a = 0; a < 4; a++) sb.push_back(t(4'(a), 1, 0, 0, 0, 0, 2'b11, 0));
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_halted(40);
    chk("nop_final_pc", {28'd0, pc}, 32'd4);
    pulse_start();
    repeat (6) @(negedge clk);
    chk("halt_sticky", {30'd0, halted, busy}, 32'd2);
    chk("halt_pc_frozen", {28'd0, pc}, 32'd4);
    chk("nop_fault_pc", {28'd0, fault_pc}, 32'd0);
    chk("nop_sb_empty", sb.size(), 32'd0);

    // LDK, JMP, ALU ops, JZ taken and not taken; start held high throughout.
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h13; rom[2] = 8'h5A;
    rom[10] = 8'h25; rom[11] = 8'h34; rom[12] = 8'h41; rom[13] = 8'h66;
    rom[6] = 8'h66; rom[7] = 8'h00; rom[8] = 8'h70;
    do_reset();
    zero_tab[13] = 1'b1;
    sb.push_back(t(0,  1, 0, 0,  0, 0, 2'b11, 0));
    sb.push_back(t(1,  1, 0, 0,  1, 0, 2'b11, 3));
    sb.push_back(t(2,  0, 1, 10, 0, 0, 2'b11, 10));
    sb.push_back(t(10, 1, 0, 0,  0, 1, 2'b00, 5));
    sb.push_back(t(11, 1, 0, 0,  0, 1, 2'b01, 4));
    sb.push_back(t(12, 1, 0, 0,  0, 1, 2'b10, 1));
    sb.push_back(t(13, 0, 1, 6,  0, 0, 2'b11, 6));
    sb.push_back(t(6,  1, 0, 0,  0, 0, 2'b11, 6));
    sb.push_back(t(7,  1, 0, 0,  0, 0, 2'b11, 0));
    @(negedge clk) start = 1'b1;
    wait_halted(100);
    start = 1'b0;
    chk("prog_final_pc", {28'd0, pc}, 32'd8);
    chk("prog_fault_pc", {28'd0, fault_pc}, 32'd0);
    chk("prog_sb_empty", sb.size(), 32'd0);

    // Illegal opcode at address 3.
    clear_rom();
    rom[3] = 8'hF0; rom[4] = 8'h70;
    do_reset();
    for (int a = 0; a < 3; a++) sb.push_back(t(4'(a), 1, 0, 0, 0, 0, 2'b11, 0));
`ifndef CU_ILLEGAL_TRAP_EN
    sb.push_back(t(3, 1, 0, 0, 0, 0, 2'b11, 0));
`endif
    pulse_start();
    wait_halted(60);
`ifdef CU_ILLEGAL_TRAP_EN
    chk("illegal_final_pc", {28'd0, pc}, 32'd3);
`else
    chk("illegal_final_pc", {28'd0, pc}, 32'd4);
`endif
    chk("illegal_fault_pc", {28'd0, fault_pc}, 32'd3);
    chk("illegal_sb_empty", sb.size(), 32'd0);

    // Reset asserted in the EXEC cycle of an XOR.
    clear_rom();
    rom[0] = 8'h25;
    do_reset();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (reg_we) break;
    end
    chk("xor_exec_seen", {31'd0, reg_we}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("reset_mid_exec", {28'd0, reg_we, pc_enable, busy, halted}, 32'd0);
    chk("reset_mid_exec_all", all_outs(), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", {30'd0, busy, halted}, 32'd0);
    chk("reset_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
